// File: rtl/rf_spi_interface_pkg.sv
// Shared encodings, frame sizes, FSM states and the SPI frame builder
// for the MRF24J40-class command interface.
package rf_spi_pkg;

  localparam logic [1:0] INST_SR = 2'b00;
  localparam logic [1:0] INST_SW = 2'b01;
  localparam logic [1:0] INST_LR = 2'b10;
  localparam logic [1:0] INST_LW = 2'b11;

  localparam int unsigned SHORT_BITS  = 16;
  localparam int unsigned LONG_BITS   = 24;
  localparam int unsigned FRAME_W     = 24;
  localparam int unsigned BIT_CNT_W   = 5;
  localparam int unsigned LONG_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } state_e;

  typedef struct packed {
    logic [1:0]             inst;
    logic [LONG_ADDR_W-1:0] addr;
    logic [7:0]             data;
  } rf_cmd_t;

  // Left-justified frame: bit FRAME_W-1 goes out first; short frames pad the tail.
  function automatic logic [FRAME_W-1:0] build_frame(input rf_cmd_t cmd);
    logic [7:0] w_data;
    w_data = cmd.inst[0] ? cmd.data : 8'h00;
    if (cmd.inst[1]) begin
      build_frame = {1'b1, cmd.addr, cmd.inst[0], 4'h0, w_data};
    end else begin
      build_frame = {1'b0, cmd.addr[5:0], cmd.inst[0], w_data, 8'h00};
    end
  endfunction

endpackage

// File: rtl/rf_spi_interface_tick.sv
// Phase timer: CLK_DIV-cycle down-counter with a one-cycle phase-end strobe,
// restarted on reset and whenever a new command is accepted.
module rf_spi_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= RELOAD;
    end else if (o_tick_c) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/rf_spi_interface.sv
// Responder end of the controller-to-RF command interface: one command per
// cs_in pulse becomes one mode-0 SPI frame; reads return the last byte shifted in.
module rf_spi_interface
  import rf_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        inst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        data_in,
  input  logic              cs_in,
  output logic              ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  input  logic              int_n,
  output logic              intr
);

  state_e                 r_state, w_state_nxt;
  logic [FRAME_W-2:0]     r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_nxt;
  logic                   r_read, w_read_nxt;
  logic [7:0]             r_rx, w_rx_nxt;
  logic [7:0]             r_rd_data, w_rd_data_nxt;
  logic                   r_rd_valid, w_rd_valid_nxt;
  logic                   r_sclk, w_sclk_nxt;
  logic                   r_mosi, w_mosi_nxt;
  logic                   r_cs_n, w_cs_n_nxt;
  logic                   r_ready, w_ready_nxt;
  logic [1:0]             r_int_sync;
  logic                   w_accept;
  logic                   w_tick;
  rf_cmd_t                w_cmd;
  logic [FRAME_W-1:0]     w_frame;

  assign w_cmd = {inst, LONG_ADDR_W'(addr_in), data_in};

  rf_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (w_accept),
    .o_tick_c (w_tick)
  );

  // State and datapath registers; every SPI pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_read     <= 1'b0;
      r_rx       <= 8'h00;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_read     <= w_read_nxt;
      r_rx       <= w_rx_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_nxt      = r_bit_cnt;
    w_read_nxt     = r_read;
    w_rx_nxt       = r_rx;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_cs_n_nxt     = r_cs_n;
    w_ready_nxt    = r_ready;
    w_accept       = 1'b0;
    w_frame        = build_frame(w_cmd);

    case (r_state)
      IDLE: begin
        if (cs_in) begin
          w_accept    = 1'b1;
          w_mosi_nxt  = w_frame[FRAME_W-1];
          w_shift_nxt = w_frame[FRAME_W-2:0];
          case (inst)
            INST_SR, INST_SW: w_bit_nxt = BIT_CNT_W'(SHORT_BITS - 1);
            INST_LR, INST_LW: w_bit_nxt = BIT_CNT_W'(LONG_BITS - 1);
            default:          w_bit_nxt = BIT_CNT_W'(SHORT_BITS - 1);
          endcase
          w_read_nxt  = ~inst[0];
          w_ready_nxt = 1'b0;
          w_cs_n_nxt  = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        // miso is captured on the same edge that raises sclk.
        if (w_tick) begin
          w_sclk_nxt  = 1'b1;
          w_rx_nxt    = {r_rx[6:0], miso};
          w_state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          w_sclk_nxt = 1'b0;
          if (r_bit_cnt != '0) begin
            w_bit_nxt   = r_bit_cnt - BIT_CNT_W'(1);
            w_mosi_nxt  = r_shift[FRAME_W-2];
            w_shift_nxt = {r_shift[FRAME_W-3:0], 1'b0};
            w_state_nxt = SHIFT_LO;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_cs_n_nxt  = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_ready_nxt = 1'b1;
          w_state_nxt = IDLE;
          if (r_read) begin
            w_rd_data_nxt  = r_rx;
            w_rd_valid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Two-flop synchroniser for the asynchronous interrupt pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_sync <= 2'b11;
    end else begin
      r_int_sync <= {r_int_sync[0], int_n};
    end
  end

  assign ready    = r_ready;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign cs_n     = r_cs_n;
  assign intr     = r_int_sync[1];

endmodule

// File: tb/tb_rf_spi_interface.sv
// Randomised bench for rf_spi_interface against a cycle-offset model of the
// frame timing, a miso responder and directed boundary scenarios.
module tb_rf_spi_interface;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] inst;
  logic [9:0] addr_in;
  logic [7:0] data_in;
  logic       cs_in;
  logic       ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       int_n;
  logic       intr;

  int checks = 0;
  int failures = 0;

  logic [23:0] cur_stream = 24'h0;

  bit          m_seen_rst = 1'b0;
  bit          m_busy = 1'b0;
  int          m_t = 0;
  int          m_len = 0;
  int          m_n = 16;
  bit          m_read = 1'b0;
  logic [23:0] m_frame = 24'h0;
  logic [7:0]  m_resp = 8'h00;
  logic [7:0]  m_rd = 8'h00;
  bit          m_valid = 1'b0;
  logic        m_d1 = 1'b1;
  logic        m_intr = 1'b1;

  always #5 clk = ~clk;

  rf_spi_interface #(.CLK_DIV(D), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .inst(inst), .addr_in(addr_in), .data_in(data_in),
    .cs_in(cs_in), .ready(ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .int_n(int_n), .intr(intr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Right-justified frame, MSB = first bit on the wire.
  function automatic logic [23:0] model_frame(input logic [1:0] i, input logic [9:0] a,
                                              input logic [7:0] d);
    logic [7:0] dd;
    dd = i[0] ? d : 8'h00;
    if (i[1]) model_frame = {1'b1, a, i[0], 4'h0, dd};
    else      model_frame = {8'h00, 1'b0, a[5:0], i[0], dd};
  endfunction

  // Behavioural model: time since accept decides every output.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_seen_rst = 1'b1;
        m_busy = 1'b0; m_t = 0; m_valid = 1'b0; m_rd = 8'h00;
        m_d1 = 1'b1; m_intr = 1'b1;
      end else begin
        m_intr = m_d1;
        m_d1   = int_n;
        if (m_busy) begin
          m_t++;
          if (m_t > m_len) begin
            m_busy  = 1'b0;
            m_valid = m_read;
            if (m_read) m_rd = m_resp;
          end
        end else begin
          m_valid = 1'b0;
          if (cs_in) begin
            m_busy  = 1'b1;
            m_t     = 1;
            m_n     = inst[1] ? 24 : 16;
            m_len   = (2 * m_n + 2) * D;
            m_read  = ~inst[0];
            m_frame = model_frame(inst, addr_in, data_in);
            m_resp  = cur_stream[7:0];
          end
        end
      end
    end
  end

  // Compare process.
  initial begin
    forever begin
      @(negedge clk);
      if (m_seen_rst && !rst) begin
        chk("rd_data", rd_data, m_rd);
        chk("intr", intr, m_intr);
        if (!m_busy) begin
          chk("idle_ready", ready, 1);
          chk("idle_cs_n", cs_n, 1);
          chk("idle_sclk", sclk, 0);
          chk("rd_valid", rd_valid, m_valid);
        end else begin
          chk("busy_ready", ready, 0);
          chk("busy_rd_valid", rd_valid, 0);
          if (m_t <= 2 * m_n * D) begin
            int k, b;
            k = m_t - 1;
            b = k / (2 * D);
            chk("shift_cs_n", cs_n, 0);
            chk("shift_sclk", sclk, ((k % (2 * D)) >= D) ? 1 : 0);
            chk("shift_mosi", mosi, m_frame[m_n - 1 - b]);
          end else if (m_t <= (2 * m_n + 1) * D) begin
            chk("hold_cs_n", cs_n, 0);
            chk("hold_sclk", sclk, 0);
          end else begin
            chk("gap_cs_n", cs_n, 1);
            chk("gap_sclk", sclk, 0);
          end
        end
      end
    end
  end

  // Transceiver responder: presents stream bit k before the k-th sclk rise.
  initial begin
    int  rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    miso  = 1'b0;
    forever begin
      @(negedge clk);
      if (cs_n !== 1'b0) rises = 0;
      else if (sclk === 1'b1 && prev !== 1'b1) rises++;
      prev = sclk;
      miso = (rises < m_n) ? cur_stream[m_n - 1 - rises] : 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL wait_ready actual=busy required=ready");
    end
  endtask

  task automatic pulse_cmd(input logic [1:0] i, input logic [9:0] a, input logic [7:0] d,
                           input logic [7:0] resp, input bit set_stream);
    if (set_stream) cur_stream = {16'($urandom()), resp};
    inst = i; addr_in = a; data_in = d; cs_in = 1'b1;
    @(negedge clk);
    cs_in = 1'b0;
    inst = 2'($urandom()); addr_in = 10'($urandom()); data_in = 8'($urandom());
  endtask

  task automatic measure(output int low, output int rises);
    logic prev;
    low = 0; rises = 0; prev = 1'b0;
    while (ready !== 1'b1 && low < 1000) begin
      low++;
      if (sclk === 1'b1 && prev !== 1'b1) rises++;
      prev = sclk;
      @(negedge clk);
    end
  endtask

  task automatic int_pulse(output int lowc);
    lowc = 0;
    int_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) int_n = 1'b1;
      if (intr === 1'b0) lowc++;
    end
  endtask

  initial begin
    int low, rises, cnt;
    rst = 1'b1; cs_in = 1'b0; inst = 2'b00; addr_in = 10'h0; data_in = 8'h0; int_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_intr", intr, 1);
    rst = 1'b0;
    chk("model_frame_sw", model_frame(2'b01, 10'h02A, 8'h5C), 24'h00555C);
    chk("model_frame_lr", model_frame(2'b10, 10'h200, 8'hFF), 24'hC00000);
    @(negedge clk);

    // Short write.
    pulse_cmd(2'b01, 10'h02A, 8'h5C, 8'h99, 1'b1);
    measure(low, rises);
    chk("sw_ready_low", low, 136);
    chk("sw_sclk_pulses", rises, 16);
    chk("sw_no_valid", rd_valid, 0);

    // Long read returning 0xA5.
    pulse_cmd(2'b10, 10'h200, 8'h00, 8'hA5, 1'b1);
    measure(low, rises);
    chk("lr_ready_low", low, 200);
    chk("lr_sclk_pulses", rises, 24);
    chk("lr_valid", rd_valid, 1);
    chk("lr_rd_data", rd_data, 8'hA5);

    // Mid-frame strobe is ignored.
    @(negedge clk);
    pulse_cmd(2'b10, 10'h155, 8'h00, 8'h3C, 1'b1);
    repeat (50) @(negedge clk);
    pulse_cmd(2'b01, 10'h00F, 8'hEE, 8'h00, 1'b0);
    wait_ready();
    chk("ign_valid", rd_valid, 1);
    chk("ign_rd_data", rd_data, 8'h3C);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rd_valid === 1'b1 || ready !== 1'b1) cnt++;
    end
    chk("ign_no_second_frame", cnt, 0);

    // Reset during bit 10 of a long read.
    pulse_cmd(2'b10, 10'h3C3, 8'h00, 8'h77, 1'b1);
    repeat (83) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_ready", ready, 1);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) cnt++;
    end
    chk("abort_no_valid", cnt, 0);
    pulse_cmd(2'b00, 10'h015, 8'h00, 8'h6B, 1'b1);
    measure(low, rises);
    chk("post_abort_low", low, 136);
    chk("post_abort_rd", rd_data, 8'h6B);

    // Back-to-back reads.
    @(negedge clk);
    pulse_cmd(2'b00, 10'h011, 8'h00, 8'h11, 1'b1);
    wait_ready();
    chk("b2b_first_rd", rd_data, 8'h11);
    pulse_cmd(2'b10, 10'h122, 8'h00, 8'h22, 1'b1);
    chk("b2b_restart_cs_n", cs_n, 0);
    wait_ready();
    chk("b2b_second_rd", rd_data, 8'h22);

    // Interrupt synchroniser, idle and mid-frame.
    repeat (4) @(negedge clk);
    int_pulse(cnt);
    chk("intr_idle_low", cnt, 3);
    pulse_cmd(2'b11, 10'h2F0, 8'h3D, 8'h00, 1'b1);
    repeat (20) @(negedge clk);
    int_pulse(cnt);
    chk("intr_busy_low", cnt, 3);
    wait_ready();

    // Random traffic with spurious strobes and interrupt noise.
    for (int it = 0; it < 25; it++) begin
      int guard;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_cmd(2'($urandom()), 10'($urandom()), 8'($urandom()), 8'($urandom()), 1'b1);
      guard = 0;
      while (ready !== 1'b1 && guard < 1000) begin
        cs_in = ($urandom_range(0, 40) == 0);
        if (cs_in) inst = 2'($urandom());
        if ($urandom_range(0, 7) == 0) int_n = ~int_n;
        @(negedge clk);
        guard++;
      end
      cs_in = 1'b0;
      if (guard >= 1000) begin
        checks++; failures++;
        $display("FAIL rand_timeout actual=busy required=ready");
      end
    end
    int_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
